// File: rtl/rib_arbiter.sv
// -----------------------------------------------------------------------------
// rib_arbiter
//
// Registered round-robin arbiter for the 4-master RIB interconnect. It samples
// the master requests and registers a one-hot grant plus the encoded owner
// index that steers the RIB address/data muxes. It also handles tenure limits,
// bus locking and a high-priority (debug) master override, and it produces the
// pipeline hold flag for the core.
//
// Parameters:
//   MAX_TENURE   cycles an unlocked owner may keep the bus while another
//                master waits (0 disables tenure preemption)
//   PRIO_MASTER  master index that bypasses round-robin and preempts
//                unlocked owners
//   FETCH_MASTER master index of the instruction-fetch port; its grant does
//                not stall the pipeline
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   req_i[3:0]   per-master bus request
//   lock_i[3:0]  per-master lock; a locked owner is never preempted
//   gnt_o[3:0]   registered one-hot grant (all zero when idle)
//   gnt_id_o     registered owner index, meaningful when gnt_valid_o=1
//   gnt_valid_o  some master owns the bus
//   hold_flag_o  combinational pipeline stall request
//   timeout_o    one-cycle pulse when an owner loses the bus to the tenure limit
// -----------------------------------------------------------------------------
module rib_arbiter #(
  parameter int MAX_TENURE   = 16,
  parameter int PRIO_MASTER  = 3,
  parameter int FETCH_MASTER = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic [3:0] lock_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_id_o,
  output logic       gnt_valid_o,
  output logic       hold_flag_o,
  output logic       timeout_o
);

  // Tenure counter only needs to reach MAX_TENURE-1.
  localparam int              TW          = (MAX_TENURE > 2) ? $clog2(MAX_TENURE) : 1;
  localparam int              TEN_LAST_I  = (MAX_TENURE > 0) ? MAX_TENURE - 1 : 0;
  localparam logic [TW-1:0]   TEN_LAST    = TW'(TEN_LAST_I);
  localparam logic            TENURE_EN   = (MAX_TENURE != 0);
  localparam logic [1:0]      PRIO_ID     = 2'(PRIO_MASTER);
  localparam logic [1:0]      FETCH_ID    = 2'(FETCH_MASTER);
  localparam logic [3:0]      FETCH_MASK  = 4'(1) << FETCH_MASTER;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        r_state;
  logic [1:0]    r_gnt_id;
  logic [1:0]    r_rr_ptr;
  logic [TW-1:0] r_tenure;
  logic [3:0]    r_gnt;
  logic          r_timeout;

  state_t        w_state_next;
  logic [1:0]    w_gnt_id_next;
  logic [1:0]    w_rr_ptr_next;
  logic [TW-1:0] w_tenure_next;
  logic [3:0]    w_gnt_next;
  logic          w_timeout_next;

  logic [3:0]    w_owner_oh;
  logic [3:0]    w_others;
  logic          w_owner_req;
  logic          w_owner_lock;

  // Priority master wins outright; otherwise search upward from the slot
  // after the last owner, wrapping. k=4 wraps back onto ptr itself.
  function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    if (mask[PRIO_ID]) begin
      pick = PRIO_ID;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = ptr + 2'(k);
        if (!found && mask[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
  endfunction

  // One-hot views of the current owner and the next grant.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_onehot
      assign w_owner_oh[gi] = (r_gnt_id == 2'(gi));
      assign w_gnt_next[gi] = (w_state_next == BUSY) && (w_gnt_id_next == 2'(gi));
    end
  endgenerate

  assign w_others     = req_i & ~w_owner_oh;
  assign w_owner_req  = req_i[r_gnt_id];
  assign w_owner_lock = lock_i[r_gnt_id];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt_id  <= 2'd0;
      r_rr_ptr  <= 2'd3;  // master 0 wins the first round-robin pick
      r_tenure  <= '0;
      r_gnt     <= 4'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_gnt_id  <= w_gnt_id_next;
      r_rr_ptr  <= w_rr_ptr_next;
      r_tenure  <= w_tenure_next;
      r_gnt     <= w_gnt_next;
      r_timeout <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_gnt_id_next  = r_gnt_id;
    w_rr_ptr_next  = r_rr_ptr;
    w_tenure_next  = r_tenure;
    w_timeout_next = 1'b0;

    case (r_state)
      IDLE: begin
        if (|req_i) begin
          w_state_next  = BUSY;
          w_gnt_id_next = pick(req_i, r_rr_ptr);
          w_rr_ptr_next = w_gnt_id_next;
          w_tenure_next = '0;
        end
      end

      BUSY: begin
        if (!w_owner_req) begin
          // Release wins over everything, including a same-cycle tenure
          // expiry, so no timeout pulse here. Handoff is back-to-back.
          if (|req_i) begin
            w_gnt_id_next = pick(req_i, r_rr_ptr);
            w_rr_ptr_next = w_gnt_id_next;
            w_tenure_next = '0;
          end else begin
            w_state_next  = IDLE;
            w_tenure_next = '0;
          end
        end else if (req_i[PRIO_ID] && (r_gnt_id != PRIO_ID) && !w_owner_lock) begin
          w_gnt_id_next = PRIO_ID;
          w_rr_ptr_next = PRIO_ID;
          w_tenure_next = '0;
        end else if (TENURE_EN && (r_tenure == TEN_LAST) && !w_owner_lock && (|w_others)) begin
          w_gnt_id_next  = pick(w_others, r_rr_ptr);
          w_rr_ptr_next  = w_gnt_id_next;
          w_tenure_next  = '0;
          w_timeout_next = 1'b1;
        end else if (TENURE_EN && (r_tenure != TEN_LAST)) begin
          w_tenure_next = r_tenure + 1'b1;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign gnt_o       = r_gnt;
  assign gnt_id_o    = r_gnt_id;
  assign gnt_valid_o = (r_state == BUSY);
  assign timeout_o   = r_timeout;

  // Stall whenever a non-fetch master owns the bus or is asking for it.
  assign hold_flag_o = (gnt_valid_o && (r_gnt_id != FETCH_ID)) || (|(req_i & ~FETCH_MASK));

endmodule

// File: tb/tb_rib_arbiter.sv
module tb_rib_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic [3:0] lock_i;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       gnt_valid_o;
  logic       hold_flag_o;
  logic       timeout_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       to;
    logic       hold;
  } exp_t;

  exp_t sb_q[$];

  rib_arbiter #(
    .MAX_TENURE  (4),
    .PRIO_MASTER (3),
    .FETCH_MASTER(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .lock_i     (lock_i),
    .gnt_o      (gnt_o),
    .gnt_id_o   (gnt_id_o),
    .gnt_valid_o(gnt_valid_o),
    .hold_flag_o(hold_flag_o),
    .timeout_o  (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue what the DUT
  // must show after the following rising edge.
  task automatic step(input logic [3:0] req, input logic [3:0] lock,
                      input logic [3:0] e_gnt, input logic [1:0] e_id,
                      input logic e_to, input logic e_hold,
                      input bit pre_chk = 1'b0, input logic pre_hold = 1'b0);
    exp_t e;
    @(negedge clk);
    req_i  = req;
    lock_i = lock;
    e.gnt  = e_gnt;
    e.id   = e_id;
    e.to   = e_to;
    e.hold = e_hold;
    sb_q.push_back(e);
    $display("step req=%b lock=%b -> exp gnt=%b id=%0d to=%0b hold=%0b",
             req, lock, e_gnt, e_id, e_to, e_hold);
    if (pre_chk) begin
      #1;
      chk("hold_pre_edge", 8'(hold_flag_o), 8'(pre_hold));
    end
  endtask

  // Monitor: compare the queued expectation after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("gnt",     8'(gnt_o),       8'(e.gnt));
        chk("valid",   8'(gnt_valid_o), 8'(|e.gnt));
        chk("timeout", 8'(timeout_o),   8'(e.to));
        chk("hold",    8'(hold_flag_o), 8'(e.hold));
        if (|e.gnt) chk("gnt_id", 8'(gnt_id_o), 8'(e.id));
      end
    end
  end

  logic [3:0] rot_gnt [13] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                               4'b0100, 4'b0100, 4'b0100, 4'b0100,
                               4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0010};
  logic [1:0] rot_id  [13] = '{2'd1, 2'd1, 2'd1, 2'd1,
                               2'd2, 2'd2, 2'd2, 2'd2,
                               2'd0, 2'd0, 2'd0, 2'd0,
                               2'd1};
  logic       rot_to  [13] = '{1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b0, 1'b0,
                               1'b1};

  initial begin
    rst    = 1'b1;
    req_i  = 4'b0000;
    lock_i = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_gnt",     8'(gnt_o),       8'h00);
    chk("rst_valid",   8'(gnt_valid_o), 8'h00);
    chk("rst_id",      8'(gnt_id_o),    8'h00);
    chk("rst_timeout", 8'(timeout_o),   8'h00);
    chk("rst_hold",    8'(hold_flag_o), 8'h00);
    rst = 1'b0;

    // First grant after reset goes to master 0, one cycle latency.
    step(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Tenure rotation with 0,1,2 requesting (pointer now at 0, so 1 first).
    for (int i = 0; i < 13; i++)
      step(4'b0111, 4'b0000, rot_gnt[i], rot_id[i], rot_to[i], 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Locked owner 0 survives tenure and the priority master.
    step(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      step(4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1);
    step(4'b1110, 4'b0001, 4'b1000, 2'd3, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Fetch owner does not stall; priority request stalls immediately.
    step(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0);
    step(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0);
    step(4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Release coinciding with tenure expiry: plain handoff, no timeout.
    step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b1);
    step(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1);

    // Lock dropped at the tenure limit: preempted on that same edge.
    for (int i = 0; i < 4; i++)
      step(4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1);
    step(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1);

    // Asynchronous reset while the timeout pulse is high.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_gnt",     8'(gnt_o),       8'h00);
    chk("async_valid",   8'(gnt_valid_o), 8'h00);
    chk("async_timeout", 8'(timeout_o),   8'h00);
    $display("async reset applied mid-grant");
    @(negedge clk);
    req_i  = 4'b0000;
    lock_i = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All request after reset: priority master wins.
    step(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 8'(sb_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
